// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch and load/store share one memory port.
// Round-robin on conflict, registered outputs, and an abort with err if m_rdy never arrives.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RESET,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    output logic        i_err,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_wmask,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,

    output logic        m_req,
    output logic        m_we,
    output logic [3:0]  m_wmask,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_rdy,

    output logic        owner
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state;
    logic [7:0] wait_cnt;
    logic       timed_out;
    logic       grant_d;
    logic       timeout_hit;

    // NOTE: always_comb assigns every output on every path, so no latch can be inferred.
    always_comb begin
        grant_d     = (i_req && d_req) ? ~owner : d_req;
        timeout_hit = ({1'b0, wait_cnt} + 9'd1) == 9'(TIMEOUT);
    end

    // NOTE: state and all outputs use non-blocking assignments and the async reset,
    // so every output is a flop that clears the instant RESET falls.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            wait_cnt  <= 8'd0;
            timed_out <= 1'b0;
            owner     <= 1'b1;
            m_req     <= 1'b0;
            m_we      <= 1'b0;
            m_wmask   <= 4'd0;
            m_addr    <= 32'd0;
            m_wdata   <= 32'd0;
            i_rdata   <= 32'd0;
            d_rdata   <= 32'd0;
            i_ack     <= 1'b0;
            i_err     <= 1'b0;
            d_ack     <= 1'b0;
            d_err     <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            i_err <= 1'b0;
            d_ack <= 1'b0;
            d_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        state    <= BUSY;
                        owner    <= grant_d;
                        wait_cnt <= 8'd0;
                        m_req    <= 1'b1;
                        if (grant_d) begin
                            m_addr  <= d_addr;
                            m_we    <= d_we;
                            m_wmask <= d_wmask;
                            m_wdata <= d_wdata;
                        end else begin
                            // Fetch is read-only whatever the data port is driving.
                            m_addr  <= i_addr;
                            m_we    <= 1'b0;
                            m_wmask <= 4'd0;
                            m_wdata <= 32'd0;
                        end
                    end
                end
                BUSY: begin
                    if (m_rdy) begin
                        state     <= RESP;
                        m_req     <= 1'b0;
                        timed_out <= 1'b0;
                        if (owner) d_rdata <= m_rdata;
                        else       i_rdata <= m_rdata;
                    end else if (timeout_hit) begin
                        state     <= RESP;
                        m_req     <= 1'b0;
                        timed_out <= 1'b1;
                        if (owner) d_rdata <= 32'd0;
                        else       i_rdata <= 32'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    if (owner) begin
                        d_ack <= 1'b1;
                        d_err <= timed_out;
                    end else begin
                        i_ack <= 1'b1;
                        i_err <= timed_out;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
